// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: core writeback (A) vs
// mul/div result (B), with a destination busy scoreboard and a starvation
// counter that guarantees B forward progress.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_waddr,
  input  logic [31:0] a_wdata,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_waddr,
  input  logic [31:0] b_wdata,
  output logic        b_ready,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_addr,
  output logic        rsv_ready,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        chk_busy1,
  output logic        chk_busy2,
  output logic [31:0] busy_vec,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;

  logic [NR-1:0]    busy_q,     busy_d;
  logic [CNT_W-1:0] starve_q,   starve_d;
  logic             rf_we_q,    rf_we_d;
  logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]    rf_wdata_q, rf_wdata_d;

  logic force_b;
  logic a_blocked;
  logic a_acc;
  logic b_acc;
  logic rsv_acc;

  // Handshakes and hazard queries; depend only on inputs and state, never on rf_*.
  always_comb begin
    force_b   = b_valid && (starve_q == CNT_W'(STARVE_LIMIT));
    a_blocked = (a_waddr != '0) && busy_q[a_waddr];
    a_ready   = !force_b && !a_blocked;
    a_acc     = a_valid && a_ready;
    b_ready   = !a_acc;
    b_acc     = b_valid && b_ready;
    rsv_ready = (rsv_addr == '0) || !busy_q[rsv_addr];
    rsv_acc   = rsv_valid && rsv_ready;
    chk_busy1 = busy_q[chk_addr1];
    chk_busy2 = busy_q[chk_addr2];
  end

  // Next state: write-port register, scoreboard update, starvation counter.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    busy_d     = busy_q;
    starve_d   = '0;

    if (a_acc) begin
      rf_we_d    = (a_waddr != '0);
      rf_waddr_d = a_waddr;
      rf_wdata_d = a_wdata;
    end else if (b_acc) begin
      rf_we_d    = (b_waddr != '0);
      rf_waddr_d = b_waddr;
      rf_wdata_d = b_wdata;
    end

    // Clear is applied after set so a same-address collision ends up cleared.
    if (rsv_acc && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (b_acc) begin
      busy_d[b_waddr] = 1'b0;
    end
    busy_d[0] = 1'b0;

    if (b_valid && !b_ready) begin
      starve_d = (starve_q == CNT_W'(STARVE_LIMIT)) ? starve_q : starve_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      busy_q     <= busy_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign busy_vec = busy_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, then random traffic
// checked against a behavioural model of the arbitration/scoreboard rules.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic        b_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rsv_ready;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic [31:0] busy_vec;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_ready(a_ready),
    .b_valid(b_valid), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_ready(b_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .busy_vec(busy_vec),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          av;
    logic [4:0]  aa;
    logic [31:0] ad;
    bit          bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    bit          rv;
    logic [4:0]  ra;
    logic [4:0]  c1;
    bit          cc;     // check the pre-edge handshake expectations
    bit          e_ar;
    bit          e_br;
    bit          e_rr;
    bit          e_c1;
    bit          e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_busy;
  } vec_t;

  localparam int NROWS = 24;
  vec_t tbl [NROWS];

  int n_vec;
  int n_fail;

  // Behavioural model state
  bit          m_busy [32];
  int          m_starve;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  function automatic vec_t mk(int r, int av, int aa, logic [31:0] ad,
                              int bv, int ba, logic [31:0] bd,
                              int rv, int ra, int c1, int cc,
                              int ear, int ebr, int err, int ec1,
                              int ewe, int ewa, logic [31:0] ewd, logic [31:0] ebusy);
    vec_t v;
    v.rst = 1'(r);  v.av = 1'(av); v.aa = 5'(aa); v.ad = ad;
    v.bv = 1'(bv);  v.ba = 5'(ba); v.bd = bd;
    v.rv = 1'(rv);  v.ra = 5'(ra); v.c1 = 5'(c1); v.cc = 1'(cc);
    v.e_ar = 1'(ear); v.e_br = 1'(ebr); v.e_rr = 1'(err); v.e_c1 = 1'(ec1);
    v.e_we = 1'(ewe); v.e_wa = 5'(ewa); v.e_wd = ewd; v.e_busy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = m_busy[i];
    return r;
  endfunction

  // Apply one cycle of stimulus; compare against table constants or the model.
  task automatic run_cycle(input vec_t v, input logic [4:0] c2, input bit use_tbl, input string tag);
    bit f_b, ar, br, rr, a_acc, b_acc;
    rst = v.rst; a_valid = v.av; a_waddr = v.aa; a_wdata = v.ad;
    b_valid = v.bv; b_waddr = v.ba; b_wdata = v.bd;
    rsv_valid = v.rv; rsv_addr = v.ra; chk_addr1 = v.c1; chk_addr2 = c2;

    f_b = v.bv && (m_starve == LIMIT);
    ar  = !f_b && !((v.aa != 0) && m_busy[v.aa]);
    br  = !(v.av && ar);
    rr  = (v.ra == 0) || !m_busy[v.ra];

    @(negedge clk);
    if (use_tbl) begin
      if (v.cc) begin
        chk({tag, " a_ready"},   32'(a_ready),   32'(v.e_ar));
        chk({tag, " b_ready"},   32'(b_ready),   32'(v.e_br));
        chk({tag, " rsv_ready"}, 32'(rsv_ready), 32'(v.e_rr));
        chk({tag, " chk_busy1"}, 32'(chk_busy1), 32'(v.e_c1));
        chk({tag, " chk_busy2"}, 32'(chk_busy2), 32'(v.e_c1));
      end
    end else begin
      chk({tag, " a_ready"},   32'(a_ready),   32'(ar));
      chk({tag, " b_ready"},   32'(b_ready),   32'(br));
      chk({tag, " rsv_ready"}, 32'(rsv_ready), 32'(rr));
      chk({tag, " chk_busy1"}, 32'(chk_busy1), 32'(m_busy[v.c1]));
      chk({tag, " chk_busy2"}, 32'(chk_busy2), 32'(m_busy[c2]));
    end

    @(posedge clk);
    #1;
    a_acc = v.av && ar;
    b_acc = v.bv && br;
    if (v.rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_starve = 0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      if (a_acc) begin
        m_we = (v.aa != 0); m_wa = v.aa; m_wd = v.ad;
      end else if (b_acc) begin
        m_we = (v.ba != 0); m_wa = v.ba; m_wd = v.bd;
      end else begin
        m_we = 1'b0;
      end
      if (v.rv && rr && v.ra != 0) m_busy[v.ra] = 1'b1;
      if (b_acc) m_busy[v.ba] = 1'b0;
      m_busy[0] = 1'b0;
      if (v.bv && !br) m_starve = (m_starve >= LIMIT) ? LIMIT : m_starve + 1;
      else             m_starve = 0;
    end

    if (use_tbl) begin
      chk({tag, " rf_we"},    32'(rf_we),    32'(v.e_we));
      chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(v.e_wa));
      chk({tag, " rf_wdata"}, rf_wdata,      v.e_wd);
      chk({tag, " busy_vec"}, busy_vec,      v.e_busy);
    end else begin
      chk({tag, " rf_we"},    32'(rf_we),    32'(m_we));
      chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(m_wa));
      chk({tag, " rf_wdata"}, rf_wdata,      m_wd);
      chk({tag, " busy_vec"}, busy_vec,      model_busy_vec());
    end
  endtask

  initial begin
    vec_t v;
    n_vec = 0; n_fail = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_starve = 0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    rst = 1'b1; a_valid = 0; a_waddr = '0; a_wdata = '0;
    b_valid = 0; b_waddr = '0; b_wdata = '0;
    rsv_valid = 0; rsv_addr = '0; chk_addr1 = '0; chk_addr2 = '0;

    //            rst av aa ad           bv ba bd     rv ra c1 cc ar br rr c1  we wa wd           busy
    tbl[0]  = mk(1, 1, 5, 32'h1111,     0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        32'h0);
    tbl[1]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0, 0, 1, 1, 0, 1, 0,  1, 5, 32'hDEADBEEF, 32'h0);
    tbl[2]  = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 1, 1, 1, 1, 0,  0, 5, 32'hDEADBEEF, 32'h0);
    // priority
    tbl[3]  = mk(0, 1, 3, 32'h33,       1, 7, 32'h77, 0, 0, 0, 1, 1, 0, 1, 0, 1, 3, 32'h33,       32'h0);
    tbl[4]  = mk(0, 0, 0, 0,            1, 7, 32'h77, 0, 0, 0, 1, 1, 1, 1, 0, 1, 7, 32'h77,       32'h0);
    // starvation: four A wins then a forced B win
    tbl[5]  = mk(0, 1, 4, 32'h44,       1, 9, 32'h99, 0, 0, 0, 1, 1, 0, 1, 0, 1, 4, 32'h44,       32'h0);
    tbl[6]  = tbl[5];
    tbl[7]  = tbl[5];
    tbl[8]  = tbl[5];
    tbl[9]  = mk(0, 1, 4, 32'h44,       1, 9, 32'h99, 0, 0, 0, 1, 0, 1, 1, 0, 1, 9, 32'h99,       32'h0);
    tbl[10] = tbl[5];
    tbl[11] = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 1, 1, 1, 1, 0,  0, 4, 32'h44,       32'h0);
    // scoreboard
    tbl[12] = mk(0, 0, 0, 0,            0, 0, 0,     1, 8, 8, 1, 1, 1, 1, 0,  0, 4, 32'h44,       32'h100);
    tbl[13] = mk(0, 0, 0, 0,            0, 0, 0,     1, 8, 8, 1, 1, 1, 0, 1,  0, 4, 32'h44,       32'h100);
    tbl[14] = mk(0, 1, 8, 32'h88,       0, 0, 0,     0, 0, 8, 1, 0, 1, 1, 1,  0, 4, 32'h44,       32'h100);
    tbl[15] = mk(0, 1, 8, 32'h88,       1, 8, 32'h80, 0, 0, 8, 1, 0, 1, 1, 1, 1, 8, 32'h80,       32'h0);
    tbl[16] = mk(0, 1, 8, 32'h88,       0, 0, 0,     0, 0, 8, 1, 1, 0, 1, 0,  1, 8, 32'h88,       32'h0);
    // r0 handling
    tbl[17] = mk(0, 0, 0, 0,            0, 0, 0,     1, 0, 0, 1, 1, 1, 1, 0,  0, 8, 32'h88,       32'h0);
    tbl[18] = mk(0, 1, 0, 32'h1234,     0, 0, 0,     0, 0, 0, 1, 1, 0, 1, 0,  0, 0, 32'h1234,     32'h0);
    // same-cycle set/clear
    tbl[19] = mk(0, 0, 0, 0,            0, 0, 0,     1, 6, 0, 1, 1, 1, 1, 0,  0, 0, 32'h1234,     32'h40);
    tbl[20] = mk(0, 0, 0, 0,            0, 0, 0,     1, 10, 0, 1, 1, 1, 1, 0, 0, 0, 32'h1234,     32'h440);
    tbl[21] = mk(0, 0, 0, 0,            1, 6, 32'h66, 1, 12, 6, 1, 1, 1, 1, 1, 1, 6, 32'h66,      32'h1400);
    tbl[22] = mk(0, 0, 0, 0,            1, 10, 32'h0A, 1, 10, 10, 1, 1, 1, 0, 1, 1, 10, 32'h0A,   32'h1000);
    // reset mid-operation beats a pending B accept
    tbl[23] = mk(1, 0, 0, 0,            1, 12, 32'hCC, 0, 0, 12, 1, 1, 1, 1, 1, 0, 0, 32'h0,      32'h0);

    @(posedge clk);
    #1;
    for (int i = 0; i < NROWS; i++) begin
      run_cycle(tbl[i], tbl[i].c1, 1'b1, $sformatf("row%0d", i));
    end

    for (int n = 0; n < 400; n++) begin
      v = tbl[0];
      v.rst = ($urandom_range(0, 49) == 0);
      v.av  = ($urandom_range(0, 9) < 6);
      v.aa  = 5'($urandom_range(0, 7));
      v.ad  = $urandom;
      v.bv  = ($urandom_range(0, 9) < 5);
      v.ba  = 5'($urandom_range(0, 7));
      v.bd  = $urandom;
      v.rv  = ($urandom_range(0, 9) < 4);
      v.ra  = 5'($urandom_range(0, 7));
      v.c1  = 5'($urandom_range(0, 15));
      run_cycle(v, 5'($urandom_range(0, 31)), 1'b0, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
